// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: detects exceptions, interrupts, MRET and WFI, then
// sequences the CSR updates, the pipeline flush and the fetch redirect.
module trap_ctrl #(
    parameter bit VECTORED_EN = 1'b1,
    parameter bit WFI_EN      = 1'b1
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        instr_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] addr_i,
    input  logic        exc_ill_i,
    input  logic        exc_ecall_i,
    input  logic        exc_ebreak_i,
    input  logic        exc_imis_i,
    input  logic        exc_lmis_i,
    input  logic        exc_smis_i,
    input  logic        mret_i,
    input  logic        wfi_i,
    input  logic        mstatus_ie_i,
    input  logic        mie_external_i,
    input  logic        mie_timer_i,
    input  logic        mie_sw_i,
    input  logic        mip_external_i,
    input  logic        mip_timer_i,
    input  logic        mip_sw_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] epc_i,
    output logic        set_cause_o,
    output logic        ie_type_o,
    output logic [3:0]  trap_cause_o,
    output logic        set_epc_o,
    output logic [31:0] epc_o,
    output logic        set_mtval_o,
    output logic [31:0] mtval_o,
    output logic        mstatus_ie_clear_o,
    output logic        mstatus_ie_set_o,
    output logic        flush_o,
    output logic        hold_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SAVE = 3'd1;
    localparam logic [2:0] S_JUMP = 3'd2;
    localparam logic [2:0] S_MRET = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        ie_type_q, ie_type_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] mtval_q, mtval_d;

    logic [2:0]  pend;
    logic        irq, exc_any, trap;
    logic [3:0]  new_cause;
    logic [31:0] new_mtval;
    logic [31:0] tvec_base, tvec_tgt;

    assign pend    = {mie_external_i & mip_external_i, mie_sw_i & mip_sw_i, mie_timer_i & mip_timer_i};
    assign irq     = mstatus_ie_i & (|pend);
    assign exc_any = exc_imis_i | exc_ill_i | exc_ebreak_i | exc_ecall_i | exc_lmis_i | exc_smis_i;
    assign trap    = instr_valid_i & (irq | exc_any);

    always_comb begin
        new_cause = 4'd0;
        new_mtval = 32'd0;
        if (irq) begin
            if (pend[2])      new_cause = 4'd11;
            else if (pend[1]) new_cause = 4'd3;
            else              new_cause = 4'd7;
        end else if (exc_imis_i) begin
            new_cause = 4'd0;
            new_mtval = addr_i;
        end else if (exc_ill_i) begin
            new_cause = 4'd2;
            new_mtval = instr_i;
        end else if (exc_ebreak_i) begin
            new_cause = 4'd3;
            new_mtval = pc_i;
        end else if (exc_ecall_i) begin
            new_cause = 4'd11;
        end else if (exc_lmis_i) begin
            new_cause = 4'd4;
            new_mtval = addr_i;
        end else begin
            new_cause = 4'd6;
            new_mtval = addr_i;
        end
    end

    // Vectoring applies only to interrupts; exceptions always land on the base.
    assign tvec_base = {mtvec_i[31:2], 2'b00};
    assign tvec_tgt  = (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && ie_type_q)
                     ? tvec_base + {26'd0, cause_q, 2'b00} : tvec_base;

    assign ie_type_o    = ie_type_q;
    assign trap_cause_o = cause_q;
    assign epc_o        = epc_q;
    assign mtval_o      = mtval_q;

    always_comb begin
        state_d            = state_q;
        ie_type_d          = ie_type_q;
        cause_d            = cause_q;
        epc_d              = epc_q;
        mtval_d            = mtval_q;
        set_cause_o        = 1'b0;
        set_epc_o          = 1'b0;
        set_mtval_o        = 1'b0;
        mstatus_ie_clear_o = 1'b0;
        mstatus_ie_set_o   = 1'b0;
        flush_o            = 1'b0;
        hold_o             = 1'b0;
        redirect_o         = 1'b0;
        redirect_pc_o      = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (trap) begin
                    flush_o   = 1'b1;
                    ie_type_d = irq;
                    cause_d   = new_cause;
                    epc_d     = pc_i;
                    mtval_d   = new_mtval;
                    state_d   = S_SAVE;
                end else if (instr_valid_i && mret_i) begin
                    flush_o = 1'b1;
                    state_d = S_MRET;
                end else if (instr_valid_i && wfi_i && WFI_EN) begin
                    state_d = S_WAIT;
                end
            end
            S_SAVE: begin
                hold_o             = 1'b1;
                flush_o            = 1'b1;
                set_cause_o        = 1'b1;
                set_epc_o          = 1'b1;
                set_mtval_o        = 1'b1;
                mstatus_ie_clear_o = 1'b1;
                state_d            = S_JUMP;
            end
            S_JUMP: begin
                hold_o        = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = tvec_tgt;
                state_d       = S_IDLE;
            end
            S_MRET: begin
                mstatus_ie_set_o = 1'b1;
                redirect_o       = 1'b1;
                redirect_pc_o    = epc_i;
                state_d          = S_IDLE;
            end
            S_WAIT: begin
                // Wake on any enabled pending source, even with MIE clear.
                if (|pend) state_d = S_IDLE;
                else       hold_o  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (n_rst_i) begin
            state_q   <= S_IDLE;
            ie_type_q <= 1'b0;
            cause_q   <= 4'd0;
            epc_q     <= 32'd0;
            mtval_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            ie_type_q <= ie_type_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            mtval_q   <= mtval_d;
        end
    end

endmodule
